// File: rtl/mux_lut_pkg.sv
// Shared types and helpers for the reconfigurable LUT unit: configuration FSM
// states, the reset truth-table pattern and the table parity function.
package mux_lut_pkg;

    typedef enum logic {
        IDLE,
        LOAD
    } cfg_state_t;

    // Reset table is NOT of select bit 0: even indices hold 1, odd indices hold 0.
    function automatic logic [63:0] default_table(input int k);
        logic [63:0] pattern;
        pattern = '0;
        for (int i = 0; i < (1 << k); i++) begin
            pattern[i] = (i % 2 == 0);
        end
        return pattern;
    endfunction

    function automatic logic even_parity(input logic [63:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/mux_lut_unit_mux_tree.sv
// Parametrised 2^K:1 combinational mux built from K levels of 2:1 stages;
// select bit l steers level l, so the LSB of sel resolves the leaves first.
module mux_tree #(
    parameter int K = 2
) (
    input  logic [(1<<K)-1:0] table_bits,
    input  logic [K-1:0]      sel,
    output logic              y
);

    localparam int T = 1 << K;

    genvar l, j;
    generate
        for (l = 0; l <= K; l++) begin : lvl
            logic [(T>>l)-1:0] v;
            if (l == 0) begin : leaf
                assign v = table_bits;
            end else begin : stage
                for (j = 0; j < (T >> l); j++) begin : pair
                    assign v[j] = sel[l-1] ? lvl[l-1].v[2*j+1] : lvl[l-1].v[2*j];
                end
            end
        end
    endgenerate

    assign y = lvl[K].v[0];

endmodule

// File: rtl/mux_lut_unit.sv
// Multi-channel K-input LUT unit with serial shadow-register table loading and a
// one-stage valid/ready evaluation pipeline. Optional macro MUX_LUT_CFG_PARITY_EN
// adds an even-parity bit to each load and a sticky cfg_err output.
module mux_lut_unit
    import mux_lut_pkg::*;
#(
    parameter int  K        = 2,
    parameter int  CHANNELS = 4,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CHANNELS*K-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CHANNELS-1:0]   out_data,
    input  logic                  cfg_start,
    input  logic [CW-1:0]         cfg_chan,
    input  logic                  cfg_bit_valid,
    input  logic                  cfg_bit,
    output logic                  cfg_busy,
    output logic                  cfg_done
`ifdef MUX_LUT_CFG_PARITY_EN
    ,
    output logic                  cfg_err
`endif
);

    localparam int T     = 1 << K;
    localparam int CNT_W = $clog2(T) + 1;
`ifdef MUX_LUT_CFG_PARITY_EN
    localparam int NBITS = T + 1;
`else
    localparam int NBITS = T;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NBITS - 1);
    localparam logic [63:0]      DEF_FULL  = default_table(K);
    localparam logic [T-1:0]     DEF_TABLE = DEF_FULL[T-1:0];

    cfg_state_t          state;
    cfg_state_t          next_state;
    logic [CW-1:0]       chan;
    logic [CNT_W-1:0]    cnt;
    logic [T-1:0]        shadow;
    logic [T-1:0]        shadow_wr;
    logic [T-1:0]        tables [CHANNELS];
    logic [CHANNELS-1:0] mux_out;
    logic                start_ok;
    logic                bit_write;
    logic                bit_last;

    assign start_ok  = cfg_start && ({1'b0, cfg_chan} < (CW+1)'(CHANNELS));
    assign bit_write = (state == LOAD) && cfg_bit_valid;
    assign bit_last  = bit_write && (cnt == LAST_IDX);

    always_comb begin
        shadow_wr = shadow;
        shadow_wr[cnt[K-1:0]] = cfg_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_ok) next_state = LOAD;
            LOAD:    if (bit_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cfg_busy = (state == LOAD);
    end

    // The active tables only change on the commit edge, so evaluation never sees a partial load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan     <= '0;
            cnt      <= '0;
            shadow   <= '0;
            cfg_done <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                tables[c] <= DEF_TABLE;
            end
`ifdef MUX_LUT_CFG_PARITY_EN
            cfg_err  <= 1'b0;
`endif
        end else begin
            cfg_done <= 1'b0;
            if (state == IDLE) begin
`ifdef MUX_LUT_CFG_PARITY_EN
                if (cfg_start) cfg_err <= 1'b0;
`endif
                if (start_ok) begin
                    chan   <= cfg_chan;
                    cnt    <= '0;
                    shadow <= '0;
                end
            end else if (bit_write) begin
                cnt <= cnt + CNT_W'(1);
`ifdef MUX_LUT_CFG_PARITY_EN
                if (bit_last) begin
                    if (cfg_bit == even_parity(64'(shadow))) begin
                        tables[chan] <= shadow;
                        cfg_done     <= 1'b1;
                    end else begin
                        cfg_err <= 1'b1;
                    end
                end else begin
                    shadow <= shadow_wr;
                end
`else
                shadow <= shadow_wr;
                if (bit_last) begin
                    tables[chan] <= shadow_wr;
                    cfg_done     <= 1'b1;
                end
`endif
            end
        end
    end

    genvar c;
    generate
        for (c = 0; c < CHANNELS; c++) begin : chan_mux
            mux_tree #(.K(K)) u_mux (
                .table_bits(tables[c]),
                .sel       (in_data[c*K +: K]),
                .y         (mux_out[c])
            );
        end
    endgenerate

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= mux_out;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_lut_unit.sv
// Directed self-checking bench for mux_lut_unit (K=2, CHANNELS=4) plus a
// CHANNELS=3 instance used to exercise illegal channel rejection.
module tb_mux_lut_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       cfg_start;
    logic [1:0] cfg_chan;
    logic       cfg_bit_valid;
    logic       cfg_bit;
    logic       cfg_busy;
    logic       cfg_done;
`ifdef MUX_LUT_CFG_PARITY_EN
    logic       cfg_err;
    logic       c3_err;
`endif

    logic       c3_in_ready;
    logic       c3_out_valid;
    logic [2:0] c3_out_data;
    logic       c3_start;
    logic [1:0] c3_chan;
    logic       c3_busy;
    logic       c3_done;

    int checks = 0;
    int errors = 0;
    logic [3:0] mt [4];

    mux_lut_unit #(.K(2), .CHANNELS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .cfg_start    (cfg_start),
        .cfg_chan     (cfg_chan),
        .cfg_bit_valid(cfg_bit_valid),
        .cfg_bit      (cfg_bit),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done)
`ifdef MUX_LUT_CFG_PARITY_EN
        ,
        .cfg_err      (cfg_err)
`endif
    );

    mux_lut_unit #(.K(2), .CHANNELS(3)) dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (1'b0),
        .in_ready     (c3_in_ready),
        .in_data      (6'b0),
        .out_valid    (c3_out_valid),
        .out_ready    (1'b1),
        .out_data     (c3_out_data),
        .cfg_start    (c3_start),
        .cfg_chan     (c3_chan),
        .cfg_bit_valid(1'b0),
        .cfg_bit      (1'b0),
        .cfg_busy     (c3_busy),
        .cfg_done     (c3_done)
`ifdef MUX_LUT_CFG_PARITY_EN
        ,
        .cfg_err      (c3_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] model_eval(input logic [7:0] d);
        logic [3:0] r;
        logic [1:0] s;
        for (int ch = 0; ch < 4; ch++) begin
            s = d[ch*2 +: 2];
            r[ch] = mt[ch][s];
        end
        return r;
    endfunction

    // Serial table load on the main DUT; counts cfg_done pulses across the load and two idle cycles.
    task automatic do_load(input logic [1:0] ch, input logic [3:0] tbl, output int done_count);
        logic [4:0] bits;
        int nb;
        bits = {^tbl, tbl};
`ifdef MUX_LUT_CFG_PARITY_EN
        nb = 5;
`else
        nb = 4;
`endif
        done_count = 0;
        cfg_start = 1'b1;
        cfg_chan  = ch;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < nb; i++) begin
            cfg_bit_valid = 1'b1;
            cfg_bit       = bits[i];
            tick();
            if (cfg_done) done_count++;
        end
        cfg_bit_valid = 1'b0;
        cfg_bit       = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (cfg_done) done_count++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++;
        if (out_data !== 4'b0000) begin errors++; $display("[TB] FAIL reset_out_data got %b expected 0000", out_data); end
        checks++;
        if (cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_cfg got busy=%b done=%b expected 0 0", cfg_busy, cfg_done);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready); end
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_default_eval();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 8'b11_10_01_00;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b0101) begin
            errors++; $display("[TB] FAIL default_eval got v=%b d=%b expected v=1 d=0101", out_valid, out_data);
        end
        in_data = 8'b00_00_00_00;
        tick();
        checks++;
        if (out_data !== 4'b1111) begin errors++; $display("[TB] FAIL default_eval_zero got %b expected 1111", out_data); end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_valid got %b expected 0", out_valid); end
    endtask

    task automatic test_load_and();
        int dc;
        do_load(2'd2, 4'b1000, dc);
        mt[2] = 4'b1000;
        checks++;
        if (dc != 1) begin errors++; $display("[TB] FAIL and_done_pulses got %0d expected 1", dc); end
        checks++;
        if (cfg_busy !== 1'b0) begin errors++; $display("[TB] FAIL and_busy_after got %b expected 0", cfg_busy); end
        in_valid = 1'b1;
        in_data  = 8'b11_11_01_00;
        tick();
        checks++;
        if (out_data !== 4'b0101) begin errors++; $display("[TB] FAIL and_sel11 got %b expected 0101", out_data); end
        in_data = 8'b11_01_01_00;
        tick();
        checks++;
        if (out_data !== 4'b0001) begin errors++; $display("[TB] FAIL and_sel01 got %b expected 0001", out_data); end
        in_data = 8'b00_00_00_00;
        tick();
        checks++;
        if (out_data !== 4'b1011) begin errors++; $display("[TB] FAIL and_others_not got %b expected 1011", out_data); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = 8'b00_00_00_00;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b1011) begin
            errors++; $display("[TB] FAIL bp_first got v=%b d=%b expected v=1 d=1011", out_valid, out_data);
        end
        in_data = 8'b11_10_01_00;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready got %b expected 0", in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'b1011) begin
                errors++; $display("[TB] FAIL bp_hold got v=%b d=%b expected v=1 d=1011", out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b0001) begin
            errors++; $display("[TB] FAIL bp_release got v=%b d=%b expected v=1 d=0001", out_valid, out_data);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        logic       mv;
        logic [3:0] md;
        logic       iv;
        logic       orr;
        logic [7:0] d;
        int         acc;
        int         cyc;
        mv  = 1'b0;
        md  = 4'b0;
        acc = 0;
        cyc = 0;
        while (acc < 20 && cyc < 300) begin
            iv  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 2) != 0);
            d   = 8'($urandom);
            in_valid  = iv;
            out_ready = orr;
            in_data   = d;
            #1;
            checks++;
            if (in_ready !== (!mv || orr)) begin
                errors++; $display("[TB] FAIL stream_in_ready cyc %0d got %b expected %b", cyc, in_ready, !mv || orr);
            end
            if (iv && (!mv || orr)) begin
                mv = 1'b1;
                md = model_eval(d);
                acc++;
            end else if (orr) begin
                mv = 1'b0;
            end
            tick();
            checks++;
            if (out_valid !== mv || (mv && out_data !== md)) begin
                errors++; $display("[TB] FAIL stream_out cyc %0d got v=%b d=%b expected v=%b d=%b", cyc, out_valid, out_data, mv, md);
            end
            cyc++;
        end
        checks++;
        if (acc < 20) begin errors++; $display("[TB] FAIL stream_timeout got %0d accepted expected 20", acc); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_commit_timing();
        logic [4:0] bits;
        int nb;
        bits = {1'b0, 4'b0110};
`ifdef MUX_LUT_CFG_PARITY_EN
        nb = 5;
`else
        nb = 4;
`endif
        cfg_start = 1'b1;
        cfg_chan  = 2'd0;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < nb - 1; i++) begin
            cfg_bit_valid = 1'b1;
            cfg_bit       = bits[i];
            tick();
        end
        cfg_bit_valid = 1'b1;
        cfg_bit       = bits[nb-1];
        in_valid      = 1'b1;
        out_ready     = 1'b1;
        in_data       = 8'h00;
        tick();
        cfg_bit_valid = 1'b0;
        checks++;
        if (cfg_done !== 1'b1) begin errors++; $display("[TB] FAIL commit_done got %b expected 1", cfg_done); end
        checks++;
        if (out_data !== 4'b1011) begin errors++; $display("[TB] FAIL commit_old_table got %b expected 1011", out_data); end
        tick();
        mt[0] = 4'b0110;
        checks++;
        if (out_data !== 4'b1010) begin errors++; $display("[TB] FAIL commit_new_table got %b expected 1010", out_data); end
        in_data = 8'h01;
        tick();
        checks++;
        if (out_data !== 4'b1011) begin errors++; $display("[TB] FAIL xor_sel01 got %b expected 1011", out_data); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_load();
        cfg_start = 1'b1;
        cfg_chan  = 2'd1;
        tick();
        cfg_start     = 1'b0;
        in_valid      = 1'b1;
        out_ready     = 1'b0;
        in_data       = 8'h00;
        for (int i = 0; i < 2; i++) begin
            cfg_bit_valid = 1'b1;
            cfg_bit       = 1'b1;
            tick();
            in_valid = 1'b0;
        end
        cfg_bit_valid = 1'b0;
        checks++;
        if (cfg_busy !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL midload_pre got busy=%b v=%b expected 1 1", cfg_busy, out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (cfg_busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL midload_reset got busy=%b v=%b expected 0 0", cfg_busy, out_valid);
        end
        #2 rst_n = 1'b1;
        for (int ch = 0; ch < 4; ch++) mt[ch] = 4'b0101;
        tick();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 8'h00;
        tick();
        checks++;
        if (out_data !== 4'b1111) begin errors++; $display("[TB] FAIL midload_tables_zero got %b expected 1111", out_data); end
        in_data = 8'b11_10_01_00;
        tick();
        checks++;
        if (out_data !== 4'b0101) begin errors++; $display("[TB] FAIL midload_tables_not got %b expected 0101", out_data); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal_chan();
        c3_start = 1'b1;
        c3_chan  = 2'd3;
        tick();
        c3_start = 1'b0;
        checks++;
        if (c3_busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_chan_busy got %b expected 0", c3_busy); end
        tick();
        checks++;
        if (c3_busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_chan_stay got %b expected 0", c3_busy); end
        c3_start = 1'b1;
        c3_chan  = 2'd2;
        tick();
        c3_start = 1'b0;
        checks++;
        if (c3_busy !== 1'b1) begin errors++; $display("[TB] FAIL legal_chan_busy got %b expected 1", c3_busy); end
    endtask

`ifdef MUX_LUT_CFG_PARITY_EN
    task automatic test_parity();
        logic [4:0] bits;
        int dc;
        bits = 5'b0_0001;
        cfg_start = 1'b1;
        cfg_chan  = 2'd3;
        tick();
        cfg_start = 1'b0;
        dc = 0;
        for (int i = 0; i < 5; i++) begin
            cfg_bit_valid = 1'b1;
            cfg_bit       = bits[i];
            tick();
            if (cfg_done) dc++;
        end
        cfg_bit_valid = 1'b0;
        tick();
        if (cfg_done) dc++;
        checks++;
        if (cfg_err !== 1'b1 || dc != 0) begin
            errors++; $display("[TB] FAIL parity_bad got err=%b done=%0d expected err=1 done=0", cfg_err, dc);
        end
        in_valid = 1'b1;
        in_data  = 8'b00_00_00_00;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_data[3] !== 1'b1) begin errors++; $display("[TB] FAIL parity_table_kept got %b expected 1", out_data[3]); end
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL parity_err_clear got %b expected 0", cfg_err); end
        bits = 5'b1_0001;
        dc = 0;
        for (int i = 0; i < 5; i++) begin
            cfg_bit_valid = 1'b1;
            cfg_bit       = bits[i];
            tick();
            if (cfg_done) dc++;
        end
        cfg_bit_valid = 1'b0;
        tick();
        checks++;
        if (dc != 1 || cfg_err !== 1'b0) begin
            errors++; $display("[TB] FAIL parity_good got done=%0d err=%b expected 1 0", dc, cfg_err);
        end
    endtask
`endif

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        out_ready     = 1'b1;
        cfg_start     = 1'b0;
        cfg_chan      = '0;
        cfg_bit_valid = 1'b0;
        cfg_bit       = 1'b0;
        c3_start      = 1'b0;
        c3_chan       = '0;
        for (int ch = 0; ch < 4; ch++) mt[ch] = 4'b0101;
        $display("[TB] starting mux_lut_unit bench");
        test_reset();
        test_default_eval();
        test_load_and();
        test_backpressure();
        test_stream();
        test_commit_timing();
        test_reset_mid_load();
        test_illegal_chan();
`ifdef MUX_LUT_CFG_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
